// File: rtl/chip8_fetch.sv
// chip8_fetch: two-byte CHIP-8 instruction fetcher with a valid/ready opcode handshake.
// Fetches the high byte at pc, then the low byte at pc+1, and holds the opcode until accepted.
// Optional macro CHIP8_FETCH_BOUND_CHECK_EN: halt with fault=1 instead of wrapping when a
// fetch starts at 0xFFF. Without it, fault is tied low and the low byte wraps to 0x000.
module chip8_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [15:0] opcode,
    output logic [11:0] op_pc,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr,
    input  logic        skip,
    output logic        fault
);

    typedef enum logic [1:0] {StFetchHi, StFetchLo, StHold, StHalt} state_e;

    localparam logic [11:0] ResetPc = 12'h200;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] opcode_q, opcode_d;
    logic [11:0] op_pc_q, op_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [11:0] redir_addr_q, redir_addr_d;
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
    logic        fault_q, fault_d;
`endif

    // Next-state, memory address and handshake decode
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hi_d         = hi_q;
        opcode_d     = opcode_q;
        op_pc_d      = op_pc_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
        fault_d      = fault_q;
`endif
        mem_addr     = op_pc_q;
        op_valid     = 1'b0;

        unique case (state_q)
            StFetchHi: begin
                mem_addr = pc_q;
                if (pc_load) begin
                    pc_d    = pc_load_addr;
                    state_d = StFetchHi;
                end else begin
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
                    if (pc_q == 12'hFFF) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        hi_d    = mem_data;
                        state_d = StFetchLo;
                    end
`else
                    hi_d    = mem_data;
                    state_d = StFetchLo;
`endif
                end
            end
            StFetchLo: begin
                mem_addr = pc_q + 12'd1;
                if (pc_load) begin
                    // Drop the captured high byte and restart at the new target
                    pc_d    = pc_load_addr;
                    state_d = StFetchHi;
                end else begin
                    opcode_d = {hi_q, mem_data};
                    op_pc_d  = pc_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                mem_addr = op_pc_q;
                op_valid = 1'b1;
                if (op_ready) begin
                    // A redirect on the handshake beats one latched earlier, which beats skip
                    if (pc_load) begin
                        pc_d = pc_load_addr;
                    end else if (redir_pend_q) begin
                        pc_d = redir_addr_q;
                    end else if (skip) begin
                        pc_d = op_pc_q + 12'd4;
                    end else begin
                        pc_d = op_pc_q + 12'd2;
                    end
                    redir_pend_d = 1'b0;
                    state_d      = StFetchHi;
                end else if (pc_load) begin
                    redir_pend_d = 1'b1;
                    redir_addr_d = pc_load_addr;
                end
            end
            StHalt: begin
                mem_addr = op_pc_q;
            end
            default: begin
                state_d = StFetchHi;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StFetchHi;
            pc_q         <= ResetPc;
            hi_q         <= 8'h00;
            opcode_q     <= 16'h0000;
            op_pc_q      <= ResetPc;
            redir_pend_q <= 1'b0;
            redir_addr_q <= 12'h000;
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hi_q         <= hi_d;
            opcode_q     <= opcode_d;
            op_pc_q      <= op_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign opcode = opcode_q;
    assign op_pc  = op_pc_q;
`ifdef CHIP8_FETCH_BOUND_CHECK_EN
    assign fault  = fault_q;
`else
    assign fault  = 1'b0;
`endif

endmodule
